// File: rtl/child_result_collector.sv
// Round-robin fan-in of NUM_CHILD leaf result ports into a show-ahead FIFO.
// Optional up_par output (even parity over {up_src, up_data}) with CHILD_RESULT_PARITY_EN.
module child_result_collector #(
   parameter int NUM_CHILD = 10,
   parameter int DATA_W    = 16,
   parameter int DEPTH     = 4,
   parameter int SRC_W     = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_CHILD-1:0]        child_valid,
   input  logic [NUM_CHILD*DATA_W-1:0] child_data,
   output logic [NUM_CHILD-1:0]        child_ready,
   output logic                        up_valid,
   output logic [DATA_W-1:0]           up_data,
   output logic [SRC_W-1:0]            up_src,
   input  logic                        up_ready,
`ifdef CHILD_RESULT_PARITY_EN
   output logic                        up_par,
`endif
   output logic [$clog2(DEPTH):0]      fifo_count,
   output logic [15:0]                 acc_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [SRC_W:0] NC = (SRC_W+1)'(NUM_CHILD);
   localparam logic [SRC_W-1:0] LAST = SRC_W'(NUM_CHILD - 1);

   logic [SRC_W-1:0]   r_rr;
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_rptr;
   logic [CW-1:0]      r_count;
   logic [15:0]        r_acc;
   logic [DATA_W-1:0]  r_mem_data [DEPTH];
   logic [SRC_W-1:0]   r_mem_src  [DEPTH];
`ifdef CHILD_RESULT_PARITY_EN
   logic               r_mem_par  [DEPTH];
`endif

   logic [2*NUM_CHILD-1:0] w_dbl;
   logic                   w_found;
   logic [SRC_W-1:0]       w_off;
   logic [SRC_W:0]         w_sum;
   logic [SRC_W-1:0]       w_gnt_idx;
   logic [DATA_W-1:0]      w_push_data;
   logic                   w_push;
   logic                   w_pop;

   // Rotate requests so the search starts at rr_ptr; pick first requester.
   always_comb begin
      w_found = 1'b0;
      w_off   = '0;
      w_dbl   = {child_valid, child_valid} >> r_rr;
      if (rst_n && (r_count != FULL)) begin
         for (int i = 0; i < NUM_CHILD; i++) begin
            if (!w_found && w_dbl[i]) begin
               w_found = 1'b1;
               w_off   = SRC_W'(i);
            end
         end
      end
   end

   // Map the rotated offset back to a child index with compare-and-wrap.
   always_comb begin
      w_sum = {1'b0, r_rr} + {1'b0, w_off};
      if (w_sum >= NC) begin
         w_sum = w_sum - NC;
      end
      w_gnt_idx = w_sum[SRC_W-1:0];
   end

   // One-hot grant and the matching data word.
   always_comb begin
      child_ready = '0;
      w_push_data = '0;
      for (int i = 0; i < NUM_CHILD; i++) begin
         if (w_found && (w_gnt_idx == SRC_W'(i))) begin
            child_ready[i] = 1'b1;
            w_push_data    = child_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign w_push = w_found;
   assign w_pop  = (r_count != '0) && up_ready;

   // Round-robin pointer and accepted-word counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr  <= '0;
         r_acc <= '0;
      end else if (w_push) begin
         r_rr  <= (w_gnt_idx == LAST) ? '0 : w_gnt_idx + SRC_W'(1);
         r_acc <= r_acc + 16'd1;
      end
   end

   // FIFO storage; a full FIFO never accepts, even when popping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_src[i]  <= '0;
`ifdef CHILD_RESULT_PARITY_EN
            r_mem_par[i]  <= 1'b0;
`endif
         end
      end else if (w_push) begin
         r_mem_data[r_wptr] <= w_push_data;
         r_mem_src[r_wptr]  <= w_gnt_idx;
`ifdef CHILD_RESULT_PARITY_EN
         r_mem_par[r_wptr]  <= ^{w_gnt_idx, w_push_data};
`endif
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         unique case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign up_valid   = (r_count != '0);
   assign up_data    = r_mem_data[r_rptr];
   assign up_src     = r_mem_src[r_rptr];
`ifdef CHILD_RESULT_PARITY_EN
   assign up_par     = r_mem_par[r_rptr];
`endif
   assign fifo_count = r_count;
   assign acc_cnt    = r_acc;

endmodule

// File: doc/child_result_collector.md
Name: child_result_collector

Overview:
- Fan-in counterpart to the generated fan-out hierarchy levels: one parent sits over NUM_CHILD leaf instances and gathers one result word from each leaf.
- Leaves offer results with valid/ready. The block arbitrates them round-robin, buffers accepted words in a small FIFO, and presents them upstream tagged with the source child index.
- Sits directly under each hierarchy node and feeds the node's parent.

Parameters:
- NUM_CHILD, 10, number of child result ports (2..16)
- DATA_W, 16, result word width
- DEPTH, 4, FIFO entries (power of two, >=2)
- SRC_W, 4, width of the source index; must be >= clog2(NUM_CHILD)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- child_valid  in  NUM_CHILD  per-child result valid
- child_data  in  NUM_CHILD*DATA_W  packed results; child i at [i*DATA_W +: DATA_W]
- child_ready  out  NUM_CHILD  one-hot grant; the word transfers this cycle when child_valid[i] and child_ready[i] are both high
- up_valid  out  1  FIFO head valid
- up_data  out  DATA_W  head result word
- up_src  out  SRC_W  head source child index
- up_ready  in  1  upstream accepts the head
- fifo_count  out  clog2(DEPTH)+1  current occupancy
- acc_cnt  out  16  total words accepted from children; wraps at 16'hFFFF -> 0

Behaviour:
- Reset: asynchronous, active low. While rst_n=0, all state clears:
  - child_ready=0, up_valid=0, up_data=0, up_src=0, fifo_count=0, acc_cnt=0
  - round-robin pointer rr_ptr=0, FIFO read/write pointers=0
  - Reset asserted mid-operation discards all FIFO contents immediately.
- Arbitration, combinational within the cycle:
  - If fifo_count < DEPTH: grant the first requesting child searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CHILD.
  - If fifo_count == DEPTH: child_ready is all zero. A pop in the same cycle does not free a slot for a push (no full-bypass).
  - child_ready is at most one-hot and never asserted to a child with child_valid=0.
- On an accepted push from child i:
  - write {i, child_data[i]} into the FIFO
  - rr_ptr <= (i+1) mod NUM_CHILD
  - acc_cnt increments by 1
- With no grant, rr_ptr holds its value.
- FIFO:
  - Show-ahead: up_valid = (fifo_count != 0); up_data/up_src come from the head entry, driven from registers.
  - Pop occurs when up_valid & up_ready.
  - Latency: a word pushed at edge N is visible on up_valid after edge N (next cycle), including when the FIFO was empty. There is no combinational child-to-up path.
  - Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- Upstream protocol:
  - up_data/up_src hold stable while up_valid=1 and up_ready=0.
  - up_ready while empty has no effect.
- Children may deassert valid without a transfer; the block tolerates this (no stickiness required).
- NUM_CHILD not a power of two: the pointer increment uses explicit compare-and-wrap, never a bit truncation.

Optional Feature:
- Macro: CHILD_RESULT_PARITY_EN.
- When defined:
  - Adds output up_par (1 bit) = even parity over {up_src, up_data}.
  - Parity is computed at push time and stored as an extra FIFO bit; it resets to 0.
- When undefined: the up_par port does not exist and the FIFO width is SRC_W+DATA_W.

Test Plan:
- Reset mid-stream: fill 3 entries, assert rst_n=0 for 1 cycle -> up_valid=0, fifo_count=0, acc_cnt=0 immediately; after release, child 0 wins first.
- Round-robin fairness: all 10 child_valid=1, up_ready=1 for 20 cycles -> grant order 0,1,...,9,0,...,9; acc_cnt=20; up_src sequence matches, each one cycle after its grant.
- Full backpressure: up_ready=0, children 2 and 7 valid with data 16'h00A2/16'h00A7 -> exactly 4 pushes (2,7,2,7); fifo_count=4; child_ready=0 thereafter; an up_ready pulse in a full cycle still yields no push that cycle.
- Wrap and skip: rr_ptr=9 after grant to 8; only child 3 valid -> child 3 granted, then rr_ptr=4.
- Counter wrap: preload via 65535 accepts -> acc_cnt=16'hFFFF; one more accept -> 0.
- Parity (macro defined): push child 5, data 16'h0001 -> up_src=5 (2 ones) + 1 one = odd, so up_par=1; data 16'h0003 -> up_par=0.
